msrv32_pc_sequencer: RTL and testbench
======================================

# msrv32_pc_sequencer

Next-PC sequencer and fetch-redirect controller: the consumer of the branch unit's taken/not-taken decision. Each fetch cycle it selects the next instruction address by priority: trap vector, MRET return, taken branch/jump target, or PC+4. It holds the architectural PC register, stalls on AHB wait states and issues a one-cycle flush after every redirect so the wrongly fetched instruction is killed. It sits between the branch unit, the immediate adder and trap/CSR logic on the input side, and the instruction bus and pipeline registers on the output side.

## Interface
- BOOT_ADDR, 32'h0000_1000, reset/boot fetch address (word aligned)
- ms_riscv32_mp_clk_in  input  1  system clock, rising edge
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset
- ahb_ready_in  input  1  instruction bus ready; 0 = stall the whole block
- branch_taken_in  input  1  taken decision from branch unit (branch, JAL, JALR)
- target_in  input  32  branch/jump target from immediate adder
- trap_taken_in  input  1  trap accepted by trap unit this cycle
- trap_address_in  input  32  trap vector (mtvec-derived)
- mret_in  input  1  MRET executing this cycle
- epc_in  input  32  return address (mepc)
- pc_out  output  32  PC of instruction in execute stage (registered)
- pc_plus_4_out  output  32  pc_out + 4 (link value for JAL/JALR)
- iaddr_out  output  32  address driven to instruction bus (combinational)
- flush_out  output  1  kill the instruction currently being fetched/decoded
- misaligned_instr_out  output  1  taken target not 4-byte aligned
- redirect_count_out  output  32  count of accepted redirects (debug)

## Operation
- FSM states: BOOT, RUN, FLUSH. Reset enters BOOT.
- Effective target: tgt = {target_in[31:1], 1'b0} (JALR LSB clear is applied unconditionally).
- Misaligned: misaligned_instr_out = branch_taken_in & tgt[1], in RUN only; a misaligned branch does NOT redirect (next = pc_out+4), and the trap unit redirects via trap_taken_in afterwards.
- next_pc priority in RUN: trap_taken_in -> trap_address_in; else mret_in -> epc_in; else branch_taken_in & ~tgt[1] -> tgt; else pc_out+4.
- redirect = RUN & (trap_taken_in | mret_in | (branch_taken_in & ~tgt[1])).
- BOOT: iaddr_out = BOOT_ADDR, flush_out = 1; on ahb_ready_in: pc_out <= BOOT_ADDR, -> RUN.
- RUN: iaddr_out = next_pc; on ahb_ready_in: pc_out <= next_pc; if redirect, increment redirect_count_out and -> FLUSH.
- FLUSH: flush_out = 1; all redirect inputs ignored (they belong to the killed instruction); iaddr_out = pc_out+4; on ahb_ready_in: pc_out <= pc_out+4, -> RUN.
- Arithmetic: all adds are 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag. redirect_count_out wraps at 2^32.

## Timing
- Reset values: pc_out = BOOT_ADDR, pc_plus_4_out = BOOT_ADDR+4, flush_out = 1, iaddr_out = BOOT_ADDR, misaligned_instr_out = 0, redirect_count_out = 0, state BOOT.
- Reset asserted mid-operation returns to BOOT immediately (asynchronous); no partial update is retained.
- iaddr_out, misaligned_instr_out and flush_out are combinational from state/inputs within the cycle. pc_out is updated at the clock edge, so the redirect target appears on pc_out one cycle after redirect.
- Stall: while ahb_ready_in = 0, state, pc_out and counter hold. iaddr_out and flush_out stay stable provided inputs are stable.
- Simultaneous trap + MRET + branch: trap wins, counted once.
- Back-to-back redirects are impossible by construction (FLUSH masks them). Minimum taken-branch penalty is one flushed slot.

## Structure
- Shared package msrv32_pkg: state enum {BOOT, RUN, FLUSH}, constant for PC increment (4), and the default BOOT_ADDR.
- One sub-module: msrv32_next_pc_mux (combinational priority select plus misalignment check). The top holds the FSM, PC register and counter.

## Test plan
- Reset with BOOT_ADDR=0x1000, ready=1 -> iaddr_out=0x1000, flush_out=1 in BOOT; next edge pc_out=0x1000; following edges pc_out 0x1004, 0x1008.
- Taken branch at pc_out=0x1008, target_in=0x2001 -> iaddr_out=0x2000; next edge pc_out=0x2000, flush_out=1, redirect_count_out=1; then pc_out=0x2004.
- branch_taken_in with target_in=0x2002 -> misaligned_instr_out=1, no redirect, pc_out advances to pc+4, counter unchanged.
- trap_taken_in, mret_in and branch_taken_in all high (trap_address_in=0x100, epc_in=0x3000) -> pc_out=0x100, counter +1 only.
- ahb_ready_in low for 3 cycles during a pending branch -> pc_out and state hold; redirect completes on the first ready cycle.
- Async reset pulse while in FLUSH -> outputs return to reset values immediately; BOOT fetch restarts at 0x1000.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 fetch sequencer.
package msrv32_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_INC            = 32'd4;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_1000;

endpackage

// File: rtl/msrv32_next_pc_mux.sv
// Priority select of the next fetch address: trap, MRET, aligned taken target, PC+4.
module msrv32_next_pc_mux
  import msrv32_pkg::*;
(
  input  logic        branch_taken_in,
  input  logic [31:0] target_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_address_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  input  logic [31:0] pc_plus_4_in,
  output logic [31:0] next_pc_out,
  output logic        redirect_out,
  output logic        misaligned_out
);

  logic [31:0] tgt;
  logic        branch_ok;

  // JALR clears bit 0; a target still misaligned on bit 1 is left to the trap unit.
  assign tgt            = target_in & ~32'd1;
  assign misaligned_out = branch_taken_in & tgt[1];
  assign branch_ok      = branch_taken_in & ~tgt[1];
  assign redirect_out   = trap_taken_in | mret_in | branch_ok;

  always_comb begin
    next_pc_out = pc_plus_4_in;
    if (trap_taken_in)  next_pc_out = trap_address_in;
    else if (mret_in)   next_pc_out = epc_in;
    else if (branch_ok) next_pc_out = tgt;
  end

endmodule

// File: rtl/msrv32_pc_sequencer.sv
// Architectural PC register, boot/run/flush FSM and redirect counter.
module msrv32_pc_sequencer
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        ahb_ready_in,
  input  logic        branch_taken_in,
  input  logic [31:0] target_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_address_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic [31:0] iaddr_out,
  output logic        flush_out,
  output logic        misaligned_instr_out,
  output logic [31:0] redirect_count_out
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus_4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        misaligned;

  assign pc_plus_4 = pc_q + PC_INC;

  msrv32_next_pc_mux u_mux (
    .branch_taken_in (branch_taken_in),
    .target_in       (target_in),
    .trap_taken_in   (trap_taken_in),
    .trap_address_in (trap_address_in),
    .mret_in         (mret_in),
    .epc_in          (epc_in),
    .pc_plus_4_in    (pc_plus_4),
    .next_pc_out     (next_pc),
    .redirect_out    (redirect),
    .misaligned_out  (misaligned)
  );

  // Redirect inputs only matter in RUN; in FLUSH they belong to the killed slot.
  always_comb begin
    state_d              = state_q;
    pc_d                 = pc_q;
    cnt_d                = cnt_q;
    iaddr_out            = BOOT_ADDR;
    flush_out            = 1'b1;
    misaligned_instr_out = 1'b0;
    case (state_q)
      BOOT: begin
        if (ahb_ready_in) begin
          pc_d    = BOOT_ADDR;
          state_d = RUN;
        end
      end
      RUN: begin
        iaddr_out            = next_pc;
        flush_out            = 1'b0;
        misaligned_instr_out = misaligned;
        if (ahb_ready_in) begin
          pc_d = next_pc;
          if (redirect) begin
            cnt_d   = cnt_q + 32'd1;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        iaddr_out = pc_plus_4;
        if (ahb_ready_in) begin
          pc_d    = pc_plus_4;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= BOOT;
      pc_q    <= BOOT_ADDR;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out             = pc_q;
  assign pc_plus_4_out      = pc_plus_4;
  assign redirect_count_out = cnt_q;

endmodule

// File: tb/tb_msrv32_pc_sequencer.sv
// Vector table with a post-edge scoreboard for msrv32_pc_sequencer.
module tb_msrv32_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b1;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic        trap = 1'b0;
  logic [31:0] trap_addr = '0;
  logic        mret = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] pc_out, pc_plus_4_out, iaddr_out, redirect_count_out;
  logic        flush_out, misaligned_instr_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  msrv32_pc_sequencer #(.BOOT_ADDR(32'h0000_1000)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .ahb_ready_in         (ready),
    .branch_taken_in      (br),
    .target_in            (tgt),
    .trap_taken_in        (trap),
    .trap_address_in      (trap_addr),
    .mret_in              (mret),
    .epc_in               (epc),
    .pc_out               (pc_out),
    .pc_plus_4_out        (pc_plus_4_out),
    .iaddr_out            (iaddr_out),
    .flush_out            (flush_out),
    .misaligned_instr_out (misaligned_instr_out),
    .redirect_count_out   (redirect_count_out)
  );

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        trap;
    logic [31:0] trap_addr;
    logic        mret;
    logic [31:0] epc;
    logic [31:0] e_iaddr;
    logic        e_flush;
    logic        e_mis;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    int          row;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic b, input logic [31:0] t,
                              input logic tr, input logic [31:0] ta, input logic m,
                              input logic [31:0] e, input logic [31:0] ia, input logic fl,
                              input logic mi, input logic [31:0] p, input logic [31:0] c);
    vec_t v;
    v.rdy = rdy; v.br = b; v.tgt = t; v.trap = tr; v.trap_addr = ta; v.mret = m; v.epc = e;
    v.e_iaddr = ia; v.e_flush = fl; v.e_mis = mi; v.e_pc = p; v.e_cnt = c;
    return v;
  endfunction

  // Drive at negedge, check combinational outputs, then score registered outputs after the edge.
  task automatic apply(input vec_t v, input int row);
    exp_t e;
    exp_t got;
    ready = v.rdy; br = v.br; tgt = v.tgt; trap = v.trap;
    trap_addr = v.trap_addr; mret = v.mret; epc = v.epc;
    #1;
    chk("iaddr", row, iaddr_out, v.e_iaddr);
    chk("flush", row, {31'd0, flush_out}, {31'd0, v.e_flush});
    chk("misaligned", row, {31'd0, misaligned_instr_out}, {31'd0, v.e_mis});
    e.pc = v.e_pc; e.cnt = v.e_cnt; e.row = row;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("pc_out", got.row, pc_out, got.pc);
    chk("pc_plus_4", got.row, pc_plus_4_out, got.pc + 32'd4);
    chk("redirect_count", got.row, redirect_count_out, got.cnt);
    @(negedge clk);
  endtask

  task automatic chk_reset(input int row);
    chk("rst_pc", row, pc_out, 32'h1000);
    chk("rst_pc4", row, pc_plus_4_out, 32'h1004);
    chk("rst_iaddr", row, iaddr_out, 32'h1000);
    chk("rst_flush", row, {31'd0, flush_out}, 32'd1);
    chk("rst_mis", row, {31'd0, misaligned_instr_out}, 32'd0);
    chk("rst_cnt", row, redirect_count_out, 32'd0);
  endtask

  initial begin
    //          rdy br tgt            trap taddr    mret epc          iaddr          fl mis pc             cnt
    vt.push_back(mk(1, 0, 32'h0,        0, 32'h0,   0, 32'h0,     32'h1000,      1, 0, 32'h1000,      0)); // 0 BOOT
    vt.push_back(mk(1, 0, 32'h0,        0, 32'h0,   0, 32'h0,     32'h1004,      0, 0, 32'h1004,      0));
    vt.push_back(mk(1, 0, 32'h0,        0, 32'h0,   0, 32'h0,     32'h1008,      0, 0, 32'h1008,      0));
    vt.push_back(mk(1, 1, 32'h2001,     0, 32'h0,   0, 32'h0,     32'h2000,      0, 0, 32'h2000,      1)); // 3 taken
    vt.push_back(mk(1, 1, 32'h5002,     0, 32'h0,   0, 32'h0,     32'h2004,      1, 0, 32'h2004,      1)); // 4 FLUSH masks
    vt.push_back(mk(1, 1, 32'h2002,     0, 32'h0,   0, 32'h0,     32'h2008,      0, 1, 32'h2008,      1)); // 5 misaligned
    vt.push_back(mk(1, 1, 32'h4000,     1, 32'h100, 1, 32'h3000,  32'h100,       0, 0, 32'h100,       2)); // 6 trap wins
    vt.push_back(mk(1, 0, 32'h0,        1, 32'h200, 0, 32'h0,     32'h104,       1, 0, 32'h104,       2)); // 7 FLUSH masks trap
    vt.push_back(mk(1, 0, 32'h0,        0, 32'h0,   1, 32'h3000,  32'h3000,      0, 0, 32'h3000,      3)); // 8 mret
    vt.push_back(mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0,     32'h3004,      1, 0, 32'h3000,      3)); // 9 stall in FLUSH
    vt.push_back(mk(1, 0, 32'h0,        0, 32'h0,   0, 32'h0,     32'h3004,      1, 0, 32'h3004,      3));
    for (int k = 0; k < 3; k++)                                                                             // 11-13 stalled branch
      vt.push_back(mk(0, 1, 32'h6000,   0, 32'h0,   0, 32'h0,     32'h6000,      0, 0, 32'h3004,      3));
    vt.push_back(mk(1, 1, 32'h6000,     0, 32'h0,   0, 32'h0,     32'h6000,      0, 0, 32'h6000,      4)); // 14 completes
    vt.push_back(mk(1, 0, 32'h0,        0, 32'h0,   0, 32'h0,     32'h6004,      1, 0, 32'h6004,      4));
    vt.push_back(mk(1, 1, 32'hFFFF_FFFC,0, 32'h0,   0, 32'h0,     32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 5));
    vt.push_back(mk(1, 0, 32'h0,        0, 32'h0,   0, 32'h0,     32'h0,         1, 0, 32'h0,         5)); // 17 wrap
    vt.push_back(mk(1, 1, 32'h3,        0, 32'h0,   0, 32'h0,     32'h4,         0, 1, 32'h4,         5)); // 18 bit0 cleared, bit1 set
    vt.push_back(mk(1, 1, 32'h40,       0, 32'h0,   0, 32'h0,     32'h40,        0, 0, 32'h40,        6)); // 19 into FLUSH

    repeat (2) @(posedge clk);
    #1;
    chk_reset(-1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Asynchronous reset mid-cycle while in FLUSH.
    #2;
    rst = 1'b1;
    #1;
    chk_reset(-2);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h1000, 1, 0, 32'h1000, 0), 100);
    apply(mk(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h1004, 0, 0, 32'h1004, 0), 101);

    chk("scoreboard_empty", 102, sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
